// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues pipelined imem requests, buffers
// {pc, instr} pairs in a small FIFO and hands them to decode via valid/ready.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [6:0]      o_OPCode,
  input  logic            i_instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic            resp_take;
  logic            push;
  logic            pop;
  logic            instr_valid;
  logic            grant;
  logic [CW:0]     in_use;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] instr_head;

  // A response arriving with nothing outstanding is stale (e.g. from before a reset).
  assign resp_take    = i_imem_rvalid && (outstanding_q != '0);
  assign push         = resp_take && (drop_q == '0) && !i_redirect;
  assign instr_valid  = (count_q != '0) && !i_redirect;
  assign pop          = instr_valid && i_instr_ready;
  assign redirect_tgt = i_redirect_pc & ~XLEN'(3);

  // A same-cycle pop frees a slot, so a 1-cycle memory streams at full rate with DEPTH=2.
  assign in_use     = {1'b0, outstanding_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};
  assign o_imem_req = i_rst_n && !i_redirect && (in_use < (CW + 1)'(DEPTH));
  assign grant      = o_imem_req && i_imem_gnt;

  assign o_imem_addr = fetch_pc_q;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_d        = drop_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(resp_take);

    if (i_redirect) begin
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      drop_d     = outstanding_q - CW'(resp_take);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (resp_take && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
        wr_ptr_d  = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // NOTE: FIFO storage is not reset; entries are only visible through count_q, which is.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= resp_pc_q;
      instr_mem[wr_ptr_q] <= i_imem_rdata;
    end
  end

  assign instr_head    = instr_valid ? instr_mem[rd_ptr_q] : '0;
  assign o_instr_valid = instr_valid;
  assign o_instr       = instr_head;
  assign o_pc          = instr_valid ? pc_mem[rd_ptr_q] : '0;
  assign o_OPCode      = instr_head[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a bench-side memory model feeds responses
// and a scoreboard of {pc, instr} predicts every word delivered to decode.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic        instr_ready = 1'b0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(imem_gnt),
    .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_instr_valid(instr_valid), .o_instr(instr), .o_pc(pc), .o_OPCode(opcode),
    .i_instr_ready(instr_ready)
  );

  // Second instance only exercises PC wrap-around from the top of the address space.
  logic        w_gnt = 1'b0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [6:0]  w_op;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_gnt(w_gnt),
    .i_imem_rvalid(1'b0), .i_imem_rdata(32'h0),
    .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_instr_valid(w_valid), .o_instr(w_instr), .o_pc(w_pc), .o_OPCode(w_op),
    .i_instr_ready(1'b0)
  );

  logic [63:0] exp_q [$];
  logic [31:0] pend  [$];
  logic [31:0] exp_addr;

  bit          gnt_en, resp_en, ready_en, redir_en;
  logic [31:0] redir_pc;

  int n_vec = 0;
  int n_err = 0;
  int n_grants, n_acc, first_valid_cyc, cyc;
  logic [31:0] first_acc_pc;
  logic        s_req, s_valid;
  logic [31:0] s_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1237;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, let them settle, check, update the models, advance.
  task automatic cycle();
    logic [63:0] e;
    cyc++;
    imem_gnt    = gnt_en;
    imem_rvalid = resp_en && (pend.size() > 0);
    imem_rdata  = imem_rvalid ? mem_word(pend[0]) : 32'h0;
    redirect    = redir_en;
    redirect_pc = redir_pc;
    instr_ready = ready_en;
    #2;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    if (redir_en) begin
      check("redir_req_low", imem_req, 32'd0);
      check("redir_valid_low", instr_valid, 32'd0);
    end
    if (imem_req) check("imem_addr", imem_addr, exp_addr);
    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", instr_valid, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", pc, e[63:32]);
        check("out_instr", instr, e[31:0]);
        check("out_opcode", {25'd0, opcode}, {25'd0, e[6:0]});
        if (n_acc == 0) first_acc_pc = pc;
        n_acc++;
      end
    end
    if (imem_rvalid) void'(pend.pop_front());
    if (redir_en) begin
      exp_q.delete();
      exp_addr = {redir_pc[31:2], 2'b00};
    end else if (imem_req && imem_gnt) begin
      pend.push_back(exp_addr);
      exp_q.push_back({exp_addr, mem_word(exp_addr)});
      exp_addr = exp_addr + 32'd4;
      n_grants++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    gnt_en = 1'b1; resp_en = 1'b1; ready_en = 1'b1; redir_en = 1'b0; redir_pc = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    #2;
    check("rst_req", imem_req, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_opcode", {25'd0, opcode}, 32'h0);
    pend.delete();
    exp_q.delete();
    exp_addr = 32'h0; n_grants = 0; n_acc = 0; first_valid_cyc = -1; cyc = 0;
    first_acc_pc = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drain();
    gnt_en = 1'b0; ready_en = 1'b1; resp_en = 1'b1; redir_en = 1'b0;
    for (int i = 0; i < 12 && (exp_q.size() != 0 || pend.size() != 0); i++) cycle();
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset, full-rate stream and wrap-around on the second instance
    w_gnt = 1'b1;
    do_reset();
    check("first_req", imem_req, 32'd1);
    check("wrap_req0", w_req, 32'd1);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    check("wrap_valid", {w_valid, w_op, 24'd0} | w_instr | w_pc, 32'h0);
    cycle();
    check("wrap_req1", w_req, 32'd1);
    check("wrap_addr1", w_addr, 32'h0000_0000);
    w_gnt = 1'b0;
    repeat (9) cycle();
    check("stream_first_valid_cyc", 32'(first_valid_cyc), 32'd3);
    check("stream_accepts", 32'(n_acc), 32'd8);
    drain();

    // Backpressure, then grant stall while the FIFO drains
    do_reset();
    ready_en = 1'b0;
    repeat (6) cycle();
    check("bp_grants", 32'(n_grants), 32'd2);
    check("bp_req_low", imem_req, 32'd0);
    gnt_en = 1'b0; ready_en = 1'b1;
    repeat (3) begin
      cycle();
      check("stall_req", s_req, 32'd1);
      check("stall_addr", s_addr, 32'h8);
    end
    check("bp_pops", 32'(n_acc), 32'd2);
    gnt_en = 1'b1;
    cycle();
    check("stall_grant_addr", s_addr, 32'h8);
    cycle();
    check("after_stall_addr", s_addr, 32'hC);
    drain();

    // Redirect with one response in flight and one entry buffered
    do_reset();
    ready_en = 1'b0; resp_en = 1'b0;
    cycle();
    resp_en = 1'b1;
    cycle();
    resp_en = 1'b0; redir_en = 1'b1; redir_pc = 32'h0000_0103;
    cycle();
    redir_en = 1'b0; resp_en = 1'b1; ready_en = 1'b1;
    cycle();
    check("redir_req", s_req, 32'd1);
    check("redir_addr", s_addr, 32'h100);
    cycle();
    drain();
    check("redir_first_pc", first_acc_pc, 32'h100);

    // Two in flight, back-to-back redirects, the second coincident with rvalid
    gnt_en = 1'b1; resp_en = 1'b0; ready_en = 1'b1; n_acc = 0;
    cycle();
    cycle();
    redir_en = 1'b1; redir_pc = 32'h0000_0203;
    cycle();
    resp_en = 1'b1; redir_pc = 32'h0000_0300;
    cycle();
    redir_en = 1'b0;
    repeat (3) cycle();
    drain();
    check("b2b_first_pc", first_acc_pc, 32'h300);

    // Redirect coincident with the only outstanding response
    do_reset();
    resp_en = 1'b0;
    cycle();
    resp_en = 1'b1; redir_en = 1'b1; redir_pc = 32'h0000_0200;
    cycle();
    redir_en = 1'b0;
    cycle();
    check("coinc_addr", s_addr, 32'h200);
    cycle();
    drain();
    check("coinc_first_pc", first_acc_pc, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
